// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multiply/divide unit owning HI/LO, fixed-latency busy window
`timescale 1ns/1ps
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   a_q, a_n, b_q, b_n;
  logic [1:0]    op_q, op_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;
  logic          launch;

  // Results are derived combinationally from the latched operands; the counter only models latency.
  logic        is_signed, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] dvd, dvs, q_mag, r_mag, quo, rem;

  always_comb begin
    is_signed = ~op_q[0];
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_ext     = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext     = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod      = a_ext * b_ext;
    // Magnitude divide keeps 0x80000000 / -1 well defined (wraps back to 0x80000000).
    dvd       = a_neg ? -a_q : a_q;
    dvs       = (b_q == 32'd0) ? 32'd1 : (b_neg ? -b_q : b_q);
    q_mag     = dvd / dvs;
    r_mag     = dvd % dvs;
    quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem       = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    // The completing edge of a run also accepts a new start, so there is no bubble.
    launch  = start && !op[2] && (state == IDLE || cnt == CW'(1));

    case (state)
      IDLE: begin
        if (!start && we) begin
          if (op == 3'd4) hi_n = a;
          else if (op == 3'd5) lo_n = a;
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          if (!op_q[1]) begin
            {hi_n, lo_n} = prod;
          end else if (b_q != 32'd0) begin
            hi_n = rem;
            lo_n = quo;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      state_n = RUN;
      a_n     = a;
      b_n     = b;
      op_n    = op[1:0];
      cnt_n   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign busy = (state == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed bench for mdu_unit with hand-computed HI/LO/busy expectations
`timescale 1ns/1ps
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int n;

  mdu_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we(we),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the sampling edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset held with start pulsing
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    start = 1'b0;
    reset = 1'b0;

    // MULT -2 * 3, launched on the first edge out of reset
    launch(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    launch(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    launch(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);

    launch(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, 32'd10);
    chk("div0_lo", lo, 32'h8000_0000);
    chk("div0_hi", hi, 32'h0000_0000);

    // DIV -100/7 with a stray start and an MTLO while in flight
    launch(3'd2, 32'hFFFF_FF9C, 32'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; we = 1'b1; op = 3'd5; a = 32'h1234;
    @(negedge clk);
    we = 1'b0; op = 3'd7;
    wait_idle(n);
    chk("coll_cycles", n + 4, 32'd10);
    chk("coll_lo", lo, 32'hFFFF_FFF2);
    chk("coll_hi", hi, 32'hFFFF_FFFE);

    // MTLO / MTHI in IDLE, and a no-op start
    we = 1'b1; op = 3'd5; a = 32'h1234;
    @(negedge clk);
    we = 1'b0; op = 3'd7;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi", hi, 32'hFFFF_FFFE);
    we = 1'b1; op = 3'd4; a = 32'hABCD_0123;
    @(negedge clk);
    we = 1'b0; op = 3'd7;
    chk("mthi_hi", hi, 32'hABCD_0123);
    chk("mthi_lo", lo, 32'h0000_1234);
    start = 1'b1; op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("nop_busy", {31'b0, busy}, 32'd0);

    // Back-to-back MULT 3x4 then MULT 5x6 on the completing edge
    launch(3'd0, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    chk("b2b_busy5", {31'b0, busy}, 32'd1);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    chk("b2b_busy_hold", {31'b0, busy}, 32'd1);
    chk("b2b_lo12", lo, 32'd12);
    chk("b2b_hi0", hi, 32'd0);
    wait_idle(n);
    chk("b2b_cycles", n, 32'd5);
    chk("b2b_lo30", lo, 32'd30);

    // Asynchronous reset in the middle of a DIVU
    launch(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    launch(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_cycles", n, 32'd10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the P6 pipelined MIPS core. It sits in the execute stage beside the ALU. It takes operands and an operation code from the E-stage decode, and owns the architectural HI/LO registers. HI/LO are read by MFHI/MFLO through the E-stage result mux. The `busy` output feeds the hazard unit, which stalls later multiply/divide-class instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: number of busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: number of busy cycles for DIV/DIVU.

Ports:
- `clk`, input, 1: the single core clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high. Clears all state immediately.
- `start`, input, 1: one-cycle pulse that launches MULT/MULTU/DIV/DIVU.
- `op`, input, 3: operation code.
  - 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
  - 4 = MTHI, 5 = MTLO.
  - 6 and 7 = no operation.
- `we`, input, 1: write strobe for MTHI/MTLO.
- `a`, input, 32: rs operand.
- `b`, input, 32: rt operand.
- `busy`, output, 1: registered; high while an operation is in flight.
- `hi`, output, 32: architectural HI register.
- `lo`, output, 32: architectural LO register.

## Operation
- State: `IDLE` and `RUN`, a cycle counter, latched operands/op, and the HI/LO registers.
- **IDLE → RUN**: on an edge where `start`=1 and `op`∈{0..3}:
  - latch `a`, `b` and `op`;
  - load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
- **In RUN**: the counter decrements every edge. When it goes 1→0, write HI/LO and return to IDLE.
- **start during RUN**: ignored; the hazard unit must prevent it. The in-flight operation is unaffected.
- **start with `op`≥4**: ignored.
- **MTHI/MTLO**: on an edge in IDLE with `we`=1 and `op`=4 (or 5), HI (or LO) ← `a`.
  - `we` during RUN is ignored.
  - If `start` and `we` are both set in the same cycle, `start` takes priority and `we` is ignored.
- **Arithmetic**:
  - MULT: 64-bit signed product. MULTU: 64-bit unsigned product. {HI,LO} ← product.
  - DIV: signed. LO ← quotient, truncated toward zero. HI ← remainder, which takes the sign of the dividend.
  - DIVU: unsigned. LO ← quotient, HI ← remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (`b`=0): HI and LO are left unchanged; `busy` still runs the full `DIV_CYCLES`.
- **Result computation**: results may be computed combinationally from the latched operands. The counter only models latency.
- **Reset**:
  - reset values: `busy`=0, `hi`=0, `lo`=0, counter=0, state IDLE;
  - reset during RUN aborts the operation with no HI/LO write;
  - the first start after reset is accepted on the first rising edge where `reset`=0.

## Timing
- `start` sampled at edge E0 → `busy`=1 in the cycles after edges E0..E(N-1). At edge EN, HI/LO update and `busy` falls.
- So `busy` is high for exactly N cycles, and new HI/LO values are visible in the same cycle `busy` is first low.
- Back-to-back: a `start` sampled at edge EN itself is accepted. IDLE is reached at EN, and that `start` is then evaluated at EN. There is no bubble.
- `busy` is registered. The hazard unit stalls on `start | busy` for md-class instructions in D.
- MTHI/MTLO: value visible on `hi`/`lo` one cycle after the write edge.
- `hi`/`lo` are register outputs with no combinational path from `a`/`b`.

## Test plan
- **Reset**: hold `reset`=1 with `start` pulsing → `busy`=0, `hi`=`lo`=0. Assert `reset` mid-cycle → outputs clear without waiting for a clock edge.
- **MULT then MULTU**:
  - MULT `a`=0xFFFFFFFE (−2), `b`=3 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **DIV signs and DIVU**:
  - DIV −7/2 → `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/−1 → LO=0x80000000, HI=0.
  - DIVU 7/0 → HI/LO unchanged.
- **Collisions**:
  - `start` (MULT 2×2) during a DIV in flight → ignored; only the DIV result lands, at cycle 10.
  - MTLO 0x1234 during RUN → ignored.
  - MTLO 0x1234 in IDLE → `lo`=0x1234 next cycle; `hi` unchanged.
- **Back-to-back**: MULT 3×4, then a `start` for MULT 5×6 on the edge where `busy` falls → LO=12 shows for one cycle, then `busy` stays high 5 more cycles, then LO=30.
- **Reset mid-DIV**: start DIVU 100/7, assert `reset` at cycle 4 → `busy`=0 and HI/LO=0 immediately. After release, DIVU 100/7 → LO=14, HI=2.
